// File: rtl/serial_buffer.sv
// Byte-stream buffer between the processor serial port and a UART rx/tx pair.
// Holds an RX FIFO, a TX FIFO and a launch FSM that paces bytes into the transmitter.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a queued byte and an idle transmitter
// START     | tx_start_out pulse; tx_byte_out already holds the byte
// WAIT_ACK  | waiting for the transmitter to raise tx_busy_in
// WAIT_DONE | waiting for the transmitter to drop tx_busy_in
module serial_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] serial_data_out,
    output logic       serial_valid_out,
    input  logic       serial_rden_in,
    input  logic [7:0] serial_data_in,
    input  logic       serial_wren_in,
    output logic       serial_ready_out,
    input  logic [7:0] rx_byte_in,
    input  logic       rx_strobe_in,
    output logic [7:0] tx_byte_out,
    output logic       tx_start_out,
    input  logic       tx_busy_in,
    output logic       overrun_out,
    output logic       overflow_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    tx_state_t tx_state_q;
    tx_state_t tx_state_d;

    // RX FIFO (UART -> processor)
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_rd_ptr;
    logic [DEPTH_LOG2-1:0] rx_wr_ptr;
    logic [DEPTH_LOG2:0]   rx_count;
    logic                  rx_empty;
    logic                  rx_full;
    logic                  rx_push;
    logic                  rx_pop;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_COUNT);
    assign rx_pop   = serial_rden_in && !rx_empty;
    // A pop in the same cycle frees the slot, so a strobe while full is still kept.
    assign rx_push  = rx_strobe_in && (!rx_full || rx_pop);

    assign serial_valid_out = !rx_empty;
    assign serial_data_out  = rx_mem[rx_rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_rd_ptr   <= '0;
            rx_wr_ptr   <= '0;
            rx_count    <= '0;
            overrun_out <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
            if (rx_strobe_in && !rx_push) overrun_out <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && rx_push) rx_mem[rx_wr_ptr] <= rx_byte_in;
    end

    // TX FIFO (processor -> UART)
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_rd_ptr;
    logic [DEPTH_LOG2-1:0] tx_wr_ptr;
    logic [DEPTH_LOG2:0]   tx_count;
    logic                  tx_empty;
    logic                  tx_full;
    logic                  tx_push;
    logic                  tx_pop;

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == FULL_COUNT);
    assign tx_pop   = (tx_state_q == IDLE) && !tx_empty && !tx_busy_in;
    assign tx_push  = serial_wren_in && (!tx_full || tx_pop);

    assign serial_ready_out = !tx_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_rd_ptr    <= '0;
            tx_wr_ptr    <= '0;
            tx_count     <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
            else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
            if (serial_wren_in && !tx_push) overflow_out <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && tx_push) tx_mem[tx_wr_ptr] <= serial_data_in;
    end

    // Launch FSM: state register, next-state logic, Moore output decode
    always_ff @(posedge clock) begin
        if (reset) tx_state_q <= IDLE;
        else       tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            IDLE:      if (!tx_empty && !tx_busy_in) tx_state_d = START;
            START:     tx_state_d = WAIT_ACK;
            WAIT_ACK:  if (tx_busy_in) tx_state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy_in) tx_state_d = IDLE;
            default:   tx_state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start_out = 1'b0;
        if (tx_state_q == START) tx_start_out = 1'b1;
    end

    // The byte is captured at the pop and held until the next launch.
    always_ff @(posedge clock) begin
        if (reset)       tx_byte_out <= 8'h00;
        else if (tx_pop) tx_byte_out <= tx_mem[tx_rd_ptr];
    end

endmodule

// File: tb/tb_serial_buffer.sv
// Self-checking bench for serial_buffer: queue-based RX model, TX launch-order
// scoreboard and a behavioural transmitter that answers tx_start_out.
module tb_serial_buffer;

    logic       clock;
    logic       reset;
    logic [7:0] serial_data_out;
    logic       serial_valid_out;
    logic       serial_rden_in;
    logic [7:0] serial_data_in;
    logic       serial_wren_in;
    logic       serial_ready_out;
    logic [7:0] rx_byte_in;
    logic       rx_strobe_in;
    logic [7:0] tx_byte_out;
    logic       tx_start_out;
    logic       tx_busy_in;
    logic       overrun_out;
    logic       overflow_out;

    serial_buffer #(.DEPTH_LOG2(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .serial_data_out  (serial_data_out),
        .serial_valid_out (serial_valid_out),
        .serial_rden_in   (serial_rden_in),
        .serial_data_in   (serial_data_in),
        .serial_wren_in   (serial_wren_in),
        .serial_ready_out (serial_ready_out),
        .rx_byte_in       (rx_byte_in),
        .rx_strobe_in     (rx_strobe_in),
        .tx_byte_out      (tx_byte_out),
        .tx_start_out     (tx_start_out),
        .tx_busy_in       (tx_busy_in),
        .overrun_out      (overrun_out),
        .overflow_out     (overflow_out)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rxq[$];
    logic [7:0] exp_tx[$];
    logic       m_overrun  = 1'b0;
    logic       m_overflow = 1'b0;

    // Transmitter mode: 0 = answers starts (busy for 10 cycles), 1 = forced busy, 2 = forced idle
    int mode       = 2;
    int starts     = 0;
    int last_start = -100;
    int fall_cyc   = -100;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Launch monitor and transmitter model, both evaluated mid-cycle
    initial begin
        logic prev_start;
        int   bcnt;
        prev_start = 1'b0;
        bcnt       = 0;
        tx_busy_in = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_start_out === 1'b1) begin
                chk("start_single_cycle", prev_start, 1'b0);
                checks++;
                assert (exp_tx.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_start: observed=%0h expected=no_pulse", tx_byte_out);
                end
                if (exp_tx.size() != 0) chk("tx_byte_order", tx_byte_out, exp_tx.pop_front());
                if (fall_cyc > last_start) chk("launch_gap_ge2", (cyc - fall_cyc) >= 2, 1'b1);
                starts++;
                last_start = cyc;
            end
            if (mode == 1) begin
                tx_busy_in = 1'b1;
                bcnt = 0;
            end else if (mode == 2) begin
                tx_busy_in = 1'b0;
                bcnt = 0;
            end else if (prev_start) begin
                tx_busy_in = 1'b1;
                bcnt = 10;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    tx_busy_in = 1'b0;
                    fall_cyc = cyc;
                end
            end else begin
                tx_busy_in = 1'b0;
            end
            prev_start = tx_start_out;
        end
    end

    // One clock cycle of stimulus; RX side and sticky flags checked against the model.
    task automatic cycle(input logic s, input logic [7:0] rb, input logic rd,
                         input logic w, input logic [7:0] wb, input logic wacc);
        logic pop;
        rx_strobe_in   = s;
        rx_byte_in     = rb;
        serial_rden_in = rd;
        serial_wren_in = w;
        serial_data_in = wb;
        #1;
        chk("rx_valid", serial_valid_out, rxq.size() != 0);
        if (rxq.size() != 0) chk("rx_data", serial_data_out, rxq[0]);
        chk("overrun", overrun_out, m_overrun);
        chk("overflow", overflow_out, m_overflow);
        @(posedge clock);
        pop = rd && (rxq.size() != 0);
        if (s && rxq.size() == 16 && !pop) m_overrun = 1'b1;
        else if (s) rxq.push_back(rb);
        if (pop) void'(rxq.pop_front());
        if (w && wacc)  exp_tx.push_back(wb);
        if (w && !wacc) m_overflow = 1'b1;
        #1;
        rx_strobe_in   = 1'b0;
        serial_rden_in = 1'b0;
        serial_wren_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int i = 0; i < budget && starts < target; i++) idle(1);
        chk("start_within_budget", starts >= target, 1'b1);
    endtask

    initial begin
        int sb;
        reset          = 1'b1;
        rx_strobe_in   = 1'b0;
        rx_byte_in     = 8'h00;
        serial_rden_in = 1'b0;
        serial_wren_in = 1'b0;
        serial_data_in = 8'h00;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state and quiet idle
        chk("reset_valid", serial_valid_out, 1'b0);
        chk("reset_ready", serial_ready_out, 1'b1);
        chk("reset_tx_byte", tx_byte_out, 8'h00);
        chk("reset_tx_start", tx_start_out, 1'b0);
        idle(10);
        chk("idle_no_starts", starts, 0);

        // RX ordering
        cycle(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(1);

        // RX full, overrun, wrap, full push+pop, empty push+pop
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("overrun_set", overrun_out, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(1);

        // TX launch with a responsive transmitter
        mode = 0;
        sb = starts;
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 1'b1);
        wait_starts(sb + 2, 80);
        idle(30);
        chk("two_launches", starts - sb, 2);
        chk("tx_byte_last", tx_byte_out, 8'hAA);

        // TX full and overflow
        mode = 2;
        sb = starts;
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1);
        wait_starts(sb + 1, 10);
        mode = 1;
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h80 + 8'(i), 1'b1);
        chk("tx_full_ready", serial_ready_out, 1'b0);
        chk("tx_byte_held", tx_byte_out, 8'h10);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hEE, 1'b0);
        chk("overflow_set", overflow_out, 1'b1);
        mode = 0;
        for (int i = 0; i < 600 && exp_tx.size() != 0; i++) idle(1);
        chk("tx_drained", exp_tx.size(), 0);
        idle(15);
        chk("tx_ready_after_drain", serial_ready_out, 1'b1);

        // Randomized traffic against the models
        for (int i = 0; i < 400; i++) begin
            logic s, rd, w;
            s  = ($urandom_range(1) == 1);
            rd = ($urandom_range(4) < 2);
            w  = (exp_tx.size() < 12) && ($urandom_range(9) == 0);
            cycle(s, 8'($urandom_range(255)), rd, w, 8'($urandom_range(255)), 1'b1);
        end
        for (int i = 0; i < 400 && exp_tx.size() != 0; i++) idle(1);
        chk("random_tx_drained", exp_tx.size(), 0);
        idle(15);

        // Reset in WAIT_DONE with bytes queued on both sides
        mode = 2;
        sb = starts;
        for (int k = 0; k < 6; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hC0 + 8'(k), 1'b1);
        wait_starts(sb + 1, 10);
        mode = 1;
        idle(3);
        for (int k = 0; k < 5; k++) cycle(1'b1, 8'hD0 + 8'(k), 1'b0, 1'b0, 8'h00, 1'b0);
        rxq.delete();
        exp_tx.delete();
        m_overrun  = 1'b0;
        m_overflow = 1'b0;
        reset          = 1'b1;
        rx_strobe_in   = 1'b1;
        serial_rden_in = 1'b1;
        serial_wren_in = 1'b1;
        @(posedge clock);
        #1;
        reset          = 1'b0;
        rx_strobe_in   = 1'b0;
        serial_rden_in = 1'b0;
        serial_wren_in = 1'b0;
        mode = 2;
        chk("midreset_valid", serial_valid_out, 1'b0);
        chk("midreset_ready", serial_ready_out, 1'b1);
        chk("midreset_tx_byte", tx_byte_out, 8'h00);
        chk("midreset_tx_start", tx_start_out, 1'b0);
        idle(20);
        chk("midreset_no_launch", starts - sb, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1);
        wait_starts(sb + 2, 8);
        chk("post_reset_launch_byte", tx_byte_out, 8'h99);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
